// File: rtl/smb_init_sequencer.sv
// SMBus init sequencer: forwards the host byte stream to the SMBus engine, or
// takes over the stream to replay a preloaded command table when started.
module smb_init_sequencer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  quiesce,
    input  logic                  cfg_wren,
    input  logic [DEPTH_LOG2-1:0] cfg_addr,
    input  logic [7:0]            cfg_wr_data,
    input  logic [DEPTH_LOG2:0]   cfg_len,
    input  logic                  cfg_start,
    output logic                  busy,
    output logic                  done,
    input  logic [7:0]            host_tdata,
    input  logic                  host_tvalid,
    output logic                  host_tready,
    input  logic                  host_open,
    output logic [7:0]            smb_tdata,
    output logic                  smb_tvalid,
    input  logic                  smb_tready,
    output logic                  smb_open
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEN_MAX = DEPTH[DEPTH_LOG2:0];

    typedef enum logic [1:0] {PASS, PEND, SEND} state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [7:0]          r_table [DEPTH];
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_done;
    logic [DEPTH_LOG2:0] r_index;
    logic [DEPTH_LOG2:0] r_len;
    logic [DEPTH_LOG2:0] w_idxNext;
    logic [DEPTH_LOG2:0] w_lenClip;
    logic                w_start;
    logic                w_load;
    logic                w_advance;
    logic                w_finish;
    logic                w_abort;

    assign w_idxNext = r_index + 1'b1;
    assign w_lenClip = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // Table is plain storage with no reset so its contents survive ap_rst_n.
    always_ff @(posedge ap_clk) begin
        if (cfg_wren && (r_state == PASS)) begin
            r_table[cfg_addr] <= cfg_wr_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= PASS;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            PASS: begin
                if (cfg_start && !quiesce) begin
                    w_start     = 1'b1;
                    w_stateNext = host_open ? PEND : SEND;
                end
            end
            PEND: begin
                if (quiesce) begin
                    w_abort     = 1'b1;
                    w_stateNext = PASS;
                end else if (!host_open) begin
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                // The first SEND cycle only fetches table[0]; a zero length finishes there.
                if (quiesce) begin
                    w_abort     = 1'b1;
                    w_stateNext = PASS;
                end else if (!r_valid) begin
                    if (r_index < r_len) begin
                        w_load = 1'b1;
                    end else begin
                        w_finish    = 1'b1;
                        w_stateNext = PASS;
                    end
                end else if (smb_tready) begin
                    if (w_idxNext < r_len) begin
                        w_advance = 1'b1;
                    end else begin
                        w_finish    = 1'b1;
                        w_stateNext = PASS;
                    end
                end
            end
            default: w_stateNext = PASS;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_index <= '0;
            r_len   <= '0;
        end else begin
            r_done <= w_finish;
            if (w_start) begin
                r_len   <= w_lenClip;
                r_index <= '0;
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_data  <= r_table[r_index[DEPTH_LOG2-1:0]];
                r_valid <= 1'b1;
            end else if (w_advance) begin
                r_index <= w_idxNext;
                r_data  <= r_table[w_idxNext[DEPTH_LOG2-1:0]];
            end else if (w_finish || w_abort) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = (r_state != PASS);
        done = r_done;
        if (r_state == PASS) begin
            smb_tdata   = host_tdata;
            smb_tvalid  = host_tvalid & ~quiesce;
            host_tready = smb_tready & ~quiesce;
            smb_open    = host_open;
        end else begin
            smb_tdata   = r_data;
            smb_tvalid  = r_valid;
            host_tready = 1'b0;
            smb_open    = 1'b1;
        end
    end
endmodule

// File: tb/tb_smb_init_sequencer.sv
// Scoreboard bench for smb_init_sequencer: expected SMBus bytes are queued by
// the stimulus and popped by a negedge monitor on every accepted transfer.
module tb_smb_init_sequencer;
    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       quiesce = 1'b0;
    logic       cfg_wren = 1'b0;
    logic [3:0] cfg_addr = 4'd0;
    logic [7:0] cfg_wr_data = 8'h00;
    logic [4:0] cfg_len = 5'd0;
    logic       cfg_start = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] host_tdata = 8'h00;
    logic       host_tvalid = 1'b0;
    logic       host_tready;
    logic       host_open = 1'b0;
    logic [7:0] smb_tdata;
    logic       smb_tvalid;
    logic       smb_tready = 1'b0;
    logic       smb_open;

    int         checkCount = 0;
    int         errorCount = 0;
    int         doneCount = 0;
    logic [7:0] expQ [$];

    smb_init_sequencer #(.DEPTH_LOG2(4)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .quiesce(quiesce),
        .cfg_wren(cfg_wren), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_len(cfg_len), .cfg_start(cfg_start), .busy(busy), .done(done),
        .host_tdata(host_tdata), .host_tvalid(host_tvalid), .host_tready(host_tready),
        .host_open(host_open), .smb_tdata(smb_tdata), .smb_tvalid(smb_tvalid),
        .smb_tready(smb_tready), .smb_open(smb_open)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every accepted SMBus byte must match the head of the scoreboard queue.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (smb_tvalid && smb_tready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpected_transfer: got 0x%0h expected none", smb_tdata);
                end else begin
                    checkOutput("smb_byte", {24'd0, smb_tdata}, {24'd0, expQ.pop_front()});
                end
            end
            if (done) doneCount++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic writeTable(input int addr, input logic [7:0] data);
        cfg_wren    = 1'b1;
        cfg_addr    = addr[3:0];
        cfg_wr_data = data;
        tick(1);
        cfg_wren    = 1'b0;
    endtask

    task automatic applyStimulus(input int len);
        cfg_len   = len[4:0];
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, input logic [3:0] readyPat, output int cycles);
        cycles = 0;
        while (!done && cycles < maxCycles) begin
            smb_tready = readyPat[cycles % 4];
            tick(1);
            cycles++;
        end
        if (!done) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", maxCycles);
        end
    endtask

    task automatic checkIdle(input string name, input int expDone);
        tick(2);
        checkOutput({name, "_queue_empty"}, expQ.size(), 0);
        checkOutput({name, "_done_count"}, doneCount, expDone);
        checkOutput({name, "_busy_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int expDone;
        logic [7:0] seqBytes [3];
        seqBytes[0] = 8'h34;
        seqBytes[1] = 8'h02;
        seqBytes[2] = 8'h9A;
        expDone = 0;

        #2;
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_smb_tvalid", {31'd0, smb_tvalid}, 0);
        checkOutput("rst_smb_open", {31'd0, smb_open}, 0);
        tick(2);
        ap_rst_n = 1'b1;
        tick(1);

        $display("[TB] basic three-byte sequence");
        for (int i = 0; i < 3; i++) writeTable(i, seqBytes[i]);
        smb_tready = 1'b1;
        applyStimulus(3);
        checkOutput("basic_busy", {31'd0, busy}, 1);
        checkOutput("basic_host_tready", {31'd0, host_tready}, 0);
        for (int i = 0; i < 3; i++) expQ.push_back(seqBytes[i]);
        expDone++;
        waitDone(20, 4'b1111, cyc);
        checkOutput("basic_latency", cyc, 4);
        checkOutput("basic_busy_at_done", {31'd0, busy}, 0);
        tick(1);
        checkOutput("basic_done_one_cycle", {31'd0, done}, 0);
        checkIdle("basic", expDone);

        $display("[TB] stalled sequence");
        for (int i = 0; i < 3; i++) expQ.push_back(seqBytes[i]);
        expDone++;
        applyStimulus(3);
        waitDone(40, 4'b1001, cyc);
        smb_tready = 1'b1;
        checkIdle("stall", expDone);

        $display("[TB] pending on open host stream");
        smb_tready = 1'b0;
        host_open  = 1'b1;
        applyStimulus(2);
        host_tdata  = 8'h55;
        host_tvalid = 1'b1;
        smb_tready  = 1'b1;
        #1;
        checkOutput("pend_busy", {31'd0, busy}, 1);
        checkOutput("pend_host_tready", {31'd0, host_tready}, 0);
        checkOutput("pend_smb_tvalid", {31'd0, smb_tvalid}, 0);
        checkOutput("pend_smb_open", {31'd0, smb_open}, 1);
        tick(2);
        checkOutput("pend_hold_busy", {31'd0, busy}, 1);
        checkOutput("pend_hold_smb_tvalid", {31'd0, smb_tvalid}, 0);
        expQ.push_back(8'h34);
        expQ.push_back(8'h02);
        expDone++;
        host_open = 1'b0;
        waitDone(20, 4'b1111, cyc);
        checkOutput("pend_latency", cyc, 4);
        expQ.push_back(8'h55);
        #1;
        checkOutput("pass_host_tready", {31'd0, host_tready}, 1);
        checkOutput("pass_smb_open", {31'd0, smb_open}, 0);
        tick(1);
        host_tvalid = 1'b0;
        checkIdle("pend", expDone);

        $display("[TB] zero length and clipped length");
        expDone++;
        applyStimulus(0);
        checkOutput("len0_smb_tvalid", {31'd0, smb_tvalid}, 0);
        waitDone(10, 4'b1111, cyc);
        checkOutput("len0_latency", cyc, 1);
        checkIdle("len0", expDone);
        for (int i = 0; i < 16; i++) writeTable(i, 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) expQ.push_back(8'hA0 + 8'(i));
        expDone++;
        applyStimulus(20);
        waitDone(40, 4'b1111, cyc);
        checkOutput("len20_latency", cyc, 17);
        checkIdle("len20", expDone);

        $display("[TB] quiesce abort");
        expQ.push_back(8'hA0);
        expQ.push_back(8'hA1);
        applyStimulus(5);
        tick(3);
        quiesce    = 1'b1;
        smb_tready = 1'b0;
        tick(1);
        checkOutput("quiesce_smb_tvalid", {31'd0, smb_tvalid}, 0);
        checkOutput("quiesce_busy", {31'd0, busy}, 0);
        checkOutput("quiesce_done", {31'd0, done}, 0);
        applyStimulus(3);
        checkOutput("quiesce_start_ignored", {31'd0, busy}, 0);
        tick(1);
        quiesce    = 1'b0;
        smb_tready = 1'b1;
        checkIdle("quiesce", expDone);

        $display("[TB] reset during sequence");
        smb_tready = 1'b0;
        applyStimulus(5);
        tick(3);
        checkOutput("rstmid_stalled_tvalid", {31'd0, smb_tvalid}, 1);
        checkOutput("rstmid_stalled_data", {24'd0, smb_tdata}, 32'hA0);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", {31'd0, busy}, 0);
        checkOutput("rstmid_smb_tvalid", {31'd0, smb_tvalid}, 0);
        checkOutput("rstmid_done", {31'd0, done}, 0);
        tick(2);
        ap_rst_n = 1'b1;
        tick(2);
        checkOutput("rstmid_pass_busy", {31'd0, busy}, 0);
        smb_tready = 1'b1;
        for (int i = 0; i < 3; i++) expQ.push_back(8'hA0 + 8'(i));
        expDone++;
        applyStimulus(3);
        waitDone(20, 4'b1111, cyc);
        checkOutput("rstmid_retained_latency", cyc, 4);
        checkIdle("rstmid", expDone);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
